// File: rtl/carregador_programa_pkg.sv
// rtl/carregador_programa_pkg.sv - shared state encoding and word geometry for the program loader
package carregador_programa_pkg;

    localparam int BYTES_POR_PALAVRA = 4;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        RECEBE  = 3'd1,
        ESCREVE = 3'd2,
        FIM     = 3'd3,
        CHECA   = 3'd4
    } estado_t;

endpackage

// File: rtl/carregador_programa_empacotador.sv
// rtl/carregador_programa_empacotador.sv - big-endian byte-to-word packer (empacotador_palavra)
module empacotador_palavra
    import carregador_programa_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        limpa,
    input  logic        captura,
    input  logic [7:0]  byte_dado,
    output logic [31:0] palavra_seguinte,
    output logic        word_completa
);

    logic [31:0] palavra;
    logic [1:0]  contagem;

    // The word as it will look once the byte on byte_dado is shifted in
    assign palavra_seguinte = {palavra[23:0], byte_dado};
    assign word_completa    = captura && (contagem == 2'(BYTES_POR_PALAVRA - 1));

    // Shift register and byte counter; the counter wraps naturally after the 4th byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            palavra  <= '0;
            contagem <= '0;
        end else if (limpa) begin
            palavra  <= '0;
            contagem <= '0;
        end else if (captura) begin
            palavra  <= palavra_seguinte;
            contagem <= contagem + 2'd1;
        end
    end

endmodule

// File: rtl/carregador_programa.sv
// rtl/carregador_programa.sv - instruction memory program loader; optional CHECKSUM_EN adds a trailing XOR check byte
module carregador_programa
    import carregador_programa_pkg::*;
#(
    parameter int NUM_PALAVRAS = 64,
    parameter int LARGURA_IDX  = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   inicio,
    input  logic [LARGURA_IDX:0]   tamanho,
    input  logic                   byte_valido,
    input  logic [7:0]             byte_dado,
    output logic                   byte_pronto,
    output logic                   mem_escrita,
    output logic [31:0]            mem_endereco,
    output logic [31:0]            mem_dado,
    output logic                   cpu_espera,
    output logic                   ocupado,
    output logic                   concluido,
    output logic                   erro
);

    localparam logic [LARGURA_IDX:0] LIMITE = (LARGURA_IDX+1)'(NUM_PALAVRAS);

    estado_t                estado, estado_prox;
    logic [LARGURA_IDX:0]   tamanho_r;
    logic [LARGURA_IDX:0]   indice;
    logic [LARGURA_IDX-1:0] endereco_r;
    logic [31:0]            dado_r;
    logic                   erro_r;
    logic                   captura;
    logic                   word_completa;
    logic [31:0]            palavra_seguinte;
    logic                   inicio_aceito;
    logic                   ultima_palavra;
`ifdef CHECKSUM_EN
    logic [7:0]             soma_xor;
`endif

    // A start is taken only from idle and only for a size the memory can hold
    assign inicio_aceito  = (estado == OCIOSO) && inicio && (tamanho <= LIMITE);
    assign captura        = byte_valido && (estado == RECEBE);
    assign ultima_palavra = ((indice + 1'b1) == tamanho_r);

    assign mem_endereco = {{(32-LARGURA_IDX-2){1'b0}}, endereco_r, 2'b00};
    assign mem_dado     = dado_r;
    assign ocupado      = (estado != OCIOSO);
    assign cpu_espera   = (estado != OCIOSO);
    assign erro         = erro_r;

    empacotador_palavra u_empacotador (
        .clk              (clk),
        .rst_n            (rst_n),
        .limpa            (inicio_aceito),
        .captura          (captura),
        .byte_dado        (byte_dado),
        .palavra_seguinte (palavra_seguinte),
        .word_completa    (word_completa)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= OCIOSO;
        end else begin
            estado <= estado_prox;
        end
    end

    // Next-state and per-state strobes
    always_comb begin
        estado_prox = estado;
        byte_pronto = 1'b0;
        mem_escrita = 1'b0;
        concluido   = 1'b0;
        case (estado)
            OCIOSO: begin
                if (inicio_aceito) begin
                    estado_prox = (tamanho == '0) ? FIM : RECEBE;
                end
            end
            RECEBE: begin
                byte_pronto = 1'b1;
                if (word_completa) begin
                    estado_prox = ESCREVE;
                end
            end
            ESCREVE: begin
                mem_escrita = 1'b1;
                if (ultima_palavra) begin
`ifdef CHECKSUM_EN
                    estado_prox = CHECA;
`else
                    estado_prox = FIM;
`endif
                end else begin
                    estado_prox = RECEBE;
                end
            end
            FIM: begin
                concluido   = 1'b1;
                estado_prox = OCIOSO;
            end
`ifdef CHECKSUM_EN
            CHECA: begin
                byte_pronto = 1'b1;
                if (byte_valido) begin
                    estado_prox = FIM;
                end
            end
`endif
            default: begin
                estado_prox = OCIOSO;
            end
        endcase
    end

    // Load bookkeeping: size, word index, held write address/data and the error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tamanho_r  <= '0;
            indice     <= '0;
            endereco_r <= '0;
            dado_r     <= '0;
            erro_r     <= 1'b0;
        end else begin
            if ((estado == OCIOSO) && inicio) begin
                if (tamanho > LIMITE) begin
                    erro_r <= 1'b1;
                end else begin
                    erro_r    <= 1'b0;
                    tamanho_r <= tamanho;
                    indice    <= '0;
                end
            end
            // Capture the finished word so address/data stay put after the write strobe
            if (word_completa) begin
                dado_r     <= palavra_seguinte;
                endereco_r <= indice[LARGURA_IDX-1:0];
            end
            if (estado == ESCREVE) begin
                indice <= indice + 1'b1;
            end
`ifdef CHECKSUM_EN
            if ((estado == CHECA) && byte_valido && (byte_dado != soma_xor)) begin
                erro_r <= 1'b1;
            end
`endif
        end
    end

`ifdef CHECKSUM_EN
    // Running XOR over every data byte of the current load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            soma_xor <= '0;
        end else if (inicio_aceito) begin
            soma_xor <= '0;
        end else if (captura) begin
            soma_xor <= soma_xor ^ byte_dado;
        end
    end
`endif

endmodule

// File: tb/tb_carregador_programa.sv
// tb/tb_carregador_programa.sv - directed self-checking bench for carregador_programa
module tb_carregador_programa;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inicio;
    logic [6:0]  tamanho;
    logic        byte_valido;
    logic [7:0]  byte_dado;
    logic        byte_pronto;
    logic        mem_escrita;
    logic [31:0] mem_endereco;
    logic [31:0] mem_dado;
    logic        cpu_espera;
    logic        ocupado;
    logic        concluido;
    logic        erro;

    int n_cmp   = 0;
    int n_falha = 0;
    int ciclo   = 0;
    int nwr     = 0;
    int nconc   = 0;
    int nesp    = 0;
    int conc_ciclo = 0;
    int c0      = 0;
    logic [31:0] wr_addr [16];
    logic [31:0] wr_data [16];

    carregador_programa dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inicio       (inicio),
        .tamanho      (tamanho),
        .byte_valido  (byte_valido),
        .byte_dado    (byte_dado),
        .byte_pronto  (byte_pronto),
        .mem_escrita  (mem_escrita),
        .mem_endereco (mem_endereco),
        .mem_dado     (mem_dado),
        .cpu_espera   (cpu_espera),
        .ocupado      (ocupado),
        .concluido    (concluido),
        .erro         (erro)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ciclo <= ciclo + 1;

    always @(negedge clk) begin
        if (mem_escrita) begin
            wr_addr[nwr % 16] = mem_endereco;
            wr_data[nwr % 16] = mem_dado;
            nwr = nwr + 1;
        end
        if (concluido) begin
            nconc      = nconc + 1;
            conc_ciclo = ciclo;
        end
        if (cpu_espera) nesp = nesp + 1;
    end

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_cmp++;
        if (obs !== esp) begin
            n_falha++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, esp);
        end
    endtask

    task automatic inicia(input logic [6:0] t);
        @(negedge clk);
        inicio  = 1'b1;
        tamanho = t;
        @(posedge clk);
        #1 c0 = ciclo;
        @(negedge clk);
        inicio = 1'b0;
    endtask

    task automatic envia(input logic [7:0] b, input int gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            byte_valido = 1'b0;
            @(negedge clk);
        end
        byte_valido = 1'b1;
        byte_dado   = b;
        n = 0;
        while (!byte_pronto && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) verifica("byte_pronto_timeout", {31'b0, byte_pronto}, 32'd1);
        @(negedge clk);
        byte_valido = 1'b0;
        byte_dado   = 8'hEE;
    endtask

    task automatic espera_fim(input int base);
        int n;
        n = 0;
        while (nconc == base && n < 200) begin
            @(negedge clk);
            n++;
        end
        verifica("concluido_count", 32'(nconc - base), 32'd1);
        @(negedge clk);
    endtask

    task automatic carga_dupla(input int gap);
        logic [7:0] bytes [8];
        int w0, cb, e0;
        bytes = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
        w0 = nwr; cb = nconc; e0 = nesp;
        inicia(7'd2);
        for (int i = 0; i < 8; i++) envia(bytes[i], gap);
`ifdef CHECKSUM_EN
        envia(8'h55, gap);
`endif
        espera_fim(cb);
        verifica("n_writes", 32'(nwr - w0), 32'd2);
        verifica("addr0", wr_addr[w0 % 16], 32'h0);
        verifica("data0", wr_data[w0 % 16], 32'h20080005);
        verifica("addr1", wr_addr[(w0 + 1) % 16], 32'h4);
        verifica("data1", wr_data[(w0 + 1) % 16], 32'h01095020);
        verifica("erro_after_load", {31'b0, erro}, 32'd0);
        verifica("ocupado_after", {31'b0, ocupado}, 32'd0);
        verifica("mem_escrita_idle", {31'b0, mem_escrita}, 32'd0);
        verifica("mem_dado_held", mem_dado, 32'h01095020);
        verifica("mem_endereco_held", mem_endereco, 32'h4);
`ifndef CHECKSUM_EN
        if (gap == 0) begin
            verifica("concluido_cycle", 32'(conc_ciclo - c0 + 1), 32'd11);
            verifica("cpu_espera_cycles", 32'(nesp - e0), 32'd11);
        end
`endif
    endtask

    initial begin
        int w0, cb;
        rst_n       = 1'b0;
        inicio      = 1'b0;
        tamanho     = '0;
        byte_valido = 1'b0;
        byte_dado   = '0;
        repeat (2) @(negedge clk);
        verifica("rst_byte_pronto", {31'b0, byte_pronto}, 32'd0);
        verifica("rst_mem_escrita", {31'b0, mem_escrita}, 32'd0);
        verifica("rst_mem_endereco", mem_endereco, 32'd0);
        verifica("rst_mem_dado", mem_dado, 32'd0);
        verifica("rst_cpu_espera", {31'b0, cpu_espera}, 32'd0);
        verifica("rst_ocupado", {31'b0, ocupado}, 32'd0);
        verifica("rst_concluido", {31'b0, concluido}, 32'd0);
        verifica("rst_erro", {31'b0, erro}, 32'd0);
        rst_n = 1'b1;

        // Two words, continuous stream
        carga_dupla(0);
        // Same stream with a gap before every byte
        carga_dupla(1);

        // Zero-length load
        w0 = nwr; cb = nconc;
        inicia(7'd0);
        espera_fim(cb);
        verifica("zero_conc_cycle", 32'(conc_ciclo - c0 + 1), 32'd1);
        verifica("zero_writes", 32'(nwr - w0), 32'd0);
        verifica("zero_erro", {31'b0, erro}, 32'd0);

        // Oversize request
        w0 = nwr; cb = nconc;
        @(negedge clk);
        inicio  = 1'b1;
        tamanho = 7'd65;
        @(negedge clk);
        inicio = 1'b0;
        verifica("over_erro", {31'b0, erro}, 32'd1);
        verifica("over_ocupado", {31'b0, ocupado}, 32'd0);
        repeat (3) @(negedge clk);
        verifica("over_ocupado_later", {31'b0, ocupado}, 32'd0);
        verifica("over_writes", 32'(nwr - w0), 32'd0);
        verifica("over_conc", 32'(nconc - cb), 32'd0);
        inicia(7'd0);
        verifica("over_erro_cleared", {31'b0, erro}, 32'd0);
        espera_fim(cb);

        // Largest legal size is accepted; abort it with reset
        inicia(7'd64);
        verifica("max_ocupado", {31'b0, ocupado}, 32'd1);
        verifica("max_byte_pronto", {31'b0, byte_pronto}, 32'd1);
        verifica("max_erro", {31'b0, erro}, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of the second word
        w0 = nwr; cb = nconc;
        inicia(7'd2);
        envia(8'h20, 0); envia(8'h08, 0); envia(8'h00, 0);
        envia(8'h05, 0); envia(8'h01, 0); envia(8'h09, 0);
        #2 rst_n = 1'b0;
        #1;
        verifica("midrst_mem_dado", mem_dado, 32'd0);
        verifica("midrst_cpu_espera", {31'b0, cpu_espera}, 32'd0);
        verifica("midrst_ocupado", {31'b0, ocupado}, 32'd0);
        verifica("midrst_byte_pronto", {31'b0, byte_pronto}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        verifica("midrst_writes", 32'(nwr - w0), 32'd1);
        verifica("midrst_no_conc", 32'(nconc - cb), 32'd0);
        w0 = nwr;
        inicia(7'd1);
        envia(8'hAA, 0); envia(8'hBB, 0); envia(8'hCC, 0); envia(8'hDD, 0);
`ifdef CHECKSUM_EN
        envia(8'h00, 0);
`endif
        espera_fim(cb);
        verifica("reload_writes", 32'(nwr - w0), 32'd1);
        verifica("reload_addr", wr_addr[w0 % 16], 32'h0);
        verifica("reload_data", wr_data[w0 % 16], 32'hAABBCCDD);

`ifdef CHECKSUM_EN
        cb = nconc;
        inicia(7'd1);
        envia(8'h12, 0); envia(8'h34, 0); envia(8'h56, 0); envia(8'h78, 0);
        envia(8'h08, 0);
        espera_fim(cb);
        verifica("cks_good_erro", {31'b0, erro}, 32'd0);
        cb = nconc;
        inicia(7'd1);
        envia(8'h12, 0); envia(8'h34, 0); envia(8'h56, 0); envia(8'h78, 0);
        envia(8'h09, 0);
        espera_fim(cb);
        verifica("cks_bad_erro", {31'b0, erro}, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_falha);
        $finish;
    end

endmodule

// File: doc/carregador_programa.md
Name: carregador_programa

Overview:
Program loader that writes into the instruction memory, which the datapath only ever reads. It accepts a byte stream on a valid/ready handshake and packs each 4 bytes big-endian into one instruction word. It writes words to consecutive word-aligned addresses through the memory's write port. While loading, it holds the PC/CPU in wait, then pulses completion.

Parameters:
NUM_PALAVRAS, 64, instruction memory depth in 32-bit words (power of 2)
LARGURA_IDX, 6, log2(NUM_PALAVRAS); width of the word index

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
inicio  in  1  start pulse; sampled only in OCIOSO
tamanho  in  LARGURA_IDX+1  number of words to load, sampled with inicio
byte_valido  in  1  source has a byte on byte_dado
byte_dado  in  8  stream byte, most significant byte of each word first
byte_pronto  out  1  loader accepts a byte this cycle
mem_escrita  out  1  one-cycle write strobe to instruction memory
mem_endereco  out  32  byte address = indice*4; bits 1:0 always 0
mem_dado  out  32  assembled instruction word
cpu_espera  out  1  holds PC/CPU while a load is in progress
ocupado  out  1  high in any state other than OCIOSO
concluido  out  1  one-cycle pulse at end of load
erro  out  1  sticky error flag, cleared by next accepted inicio

Behaviour:
- Reset (async, rst_n=0): state OCIOSO. All outputs 0, including byte index, word index, shift register and erro.
- Reset mid-load: the partial word is discarded. Memory keeps any words already written. No concluido pulse.
- Handshake: a byte transfers on a rising edge with byte_valido=1 and byte_pronto=1. byte_dado is ignored otherwise. byte_pronto=1 only in RECEBE (and CHECA if enabled).
- OCIOSO:
  - inicio=1 and tamanho > NUM_PALAVRAS: set erro=1, stay OCIOSO, no writes.
  - inicio=1 and tamanho = 0: clear erro, go to FIM (no writes).
  - Otherwise: clear erro, latch tamanho, reset indice and byte count, go to RECEBE.
- RECEBE: each transfer shifts the byte in (palavra = {palavra[23:0], byte}). On the 4th byte of a word, go to ESCREVE next cycle. Gaps in byte_valido simply stall.
- ESCREVE: mem_escrita=1 for exactly one cycle, with mem_endereco=indice<<2 and mem_dado=palavra. byte_pronto=0 here, giving one bubble per word. Then indice increments.
  - indice+1 = tamanho: go to FIM (or CHECA if enabled).
  - Otherwise: back to RECEBE.
- FIM: concluido=1 for one cycle, then OCIOSO.
- cpu_espera: 1 from the cycle after inicio is accepted through FIM inclusive; 0 in OCIOSO.
- Throughput with continuous valid: 5 cycles per word. A load of N words asserts concluido in cycle 5N+1 after the inicio edge.
- inicio while ocupado is ignored. A byte presented while not ready is not consumed.
- mem_endereco and mem_dado hold their last values outside ESCREVE. mem_escrita is 0 outside ESCREVE.

Optional Feature:
Macro CHECKSUM_EN.
- Defined: a running XOR of all accepted data bytes is kept. After the last ESCREVE, the FSM enters CHECA and accepts one extra byte. If it is not equal to the XOR, erro is set to 1. FIM/concluido follows either way. cpu_espera also covers CHECA.
- Undefined: no CHECA state and no XOR register. The stream is exactly 4*tamanho bytes.

Decomposition:
- Shared package: the state encoding constants (OCIOSO=0, RECEBE=1, ESCREVE=2, FIM=3, CHECA=4) and the BYTES_POR_PALAVRA=4 constant.
- One natural sub-module, empacotador_palavra: byte shift register, 2-bit byte counter and word_completa flag.

Test Plan:
- tamanho=2, bytes 20 08 00 05 01 09 50 20 streamed continuously -> write addr 0x0 data 0x20080005; write addr 0x4 data 0x01095020; concluido at cycle 11; cpu_espera high cycles 1..11.
- Same stream with byte_valido low every other cycle -> identical writes, concluido later, no byte dropped or duplicated.
- tamanho=0 -> no mem_escrita; concluido pulses one cycle after inicio; erro=0.
- tamanho=65 (NUM_PALAVRAS=64) -> erro=1, no writes, ocupado stays 0; next valid inicio clears erro.
- rst_n low after 6 bytes of a 2-word load -> word 0 written, word 1 never written, all outputs 0 asynchronously; a new load then starts at addr 0x0.
- CHECKSUM_EN, tamanho=1, bytes 12 34 56 78 then 08 -> erro=0; a trailing byte of 09 instead -> erro=1; concluido pulses in both cases.
